// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the PC, issues one
// request at a time to a variable-latency instruction memory, buffers the
// returned word and offers it (or a nop bubble) to the IF/ID register.
// Branch/jump redirects from D take effect after the delay-slot instruction.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   stall                1 = IF/ID holds; 0 = IF/ID loads the F outputs this edge
//   redirect_en/_pc      D-stage taken branch/jump and its target
//   imem_req/_addr       one-cycle request pulse and byte address
//   imem_rvalid/_rdata   one-cycle response and instruction word
//   instr_f, pc_f        instruction (0 = nop) and its PC for IF/ID
//   valid_f              instr_f is a real fetched slot
//   exc_f                held slot is an address fault (instr_f forced to 0)
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BYTES = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic        valid_f,
  output logic        exc_f
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_q;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        buf_exc;
  logic [31:0] tgt_q;
  logic        tgt_valid;

  logic        pc_ok;
  logic        capture;
  logic        take_fault;
  logic        take_resp;
  logic        consume;

  // Subtracting only after the lower-bound test keeps the check correct for a
  // PC that wrapped past 2^32 or sits below RESET_PC.
  assign pc_ok = (pc_q[1:0] == 2'b00) && (pc_q >= RESET_PC) &&
                 ((pc_q - RESET_PC) < IMEM_BYTES);

  // A redirect is only real on the edge the branch leaves D; while stalled D
  // keeps presenting it.
  assign capture = redirect_en && !stall;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    imem_req   = 1'b0;
    imem_addr  = pc_q;
    instr_f    = 32'h0;
    pc_f       = pc_q;
    valid_f    = 1'b0;
    exc_f      = 1'b0;
    take_fault = 1'b0;
    take_resp  = 1'b0;
    consume    = 1'b0;
    unique case (state)
      S_ISSUE: begin
        if (pc_ok) begin
          imem_req = 1'b1;
          state_d  = S_WAIT;
        end else begin
          // Bad PC never reaches memory; it becomes a faulting slot instead.
          take_fault = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          take_resp = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_f = buf_instr;
        pc_f    = buf_pc;
        valid_f = 1'b1;
        exc_f   = buf_exc;
        if (!stall) begin
          consume = 1'b1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_ISSUE;
    else       state <= state_d;
  end

  // NOTE: the slot buffer and target are ordinary registers, so they are
  // cleared on reset like the rest; the memory drops in-flight requests on
  // reset, so nothing stale can refill them afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      buf_instr <= 32'h0;
      buf_pc    <= 32'h0;
      buf_exc   <= 1'b0;
      tgt_q     <= 32'h0;
      tgt_valid <= 1'b0;
    end else begin
      if (take_fault) begin
        buf_instr <= 32'h0;
        buf_pc    <= pc_q;
        buf_exc   <= 1'b1;
      end else if (take_resp) begin
        buf_instr <= imem_rdata;
        buf_pc    <= pc_q;
        buf_exc   <= 1'b0;
      end

      if (consume) begin
        // The slot leaving now is the delay slot when a redirect arrives on
        // the same edge, so the target applies immediately.
        if (capture)        pc_q <= redirect_pc;
        else if (tgt_valid) pc_q <= tgt_q;
        else                pc_q <= pc_q + 32'd4;
        tgt_valid <= 1'b0;
      end else if (capture) begin
        tgt_q     <= redirect_pc;
        tgt_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed scenarios followed by a randomized phase. A variable-latency memory
// model answers requests; a slot-level reference model predicts, every cycle,
// which PC is being fetched or held, whether a slot is on offer, and what the
// F outputs must be.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] IMEM_BYTES = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic        valid_f;
  logic        exc_f;

  if_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_f     (instr_f),
    .pc_f        (pc_f),
    .valid_f     (valid_f),
    .exc_f       (exc_f)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state.
  int          lat = 1;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          spurious_en = 0;

  // Slot-level reference model.
  bit          model_on = 0;
  logic [31:0] m_pc = 32'h0;
  bit          m_ready = 0;   // a slot for m_pc is on offer
  bit          m_fresh = 0;   // first cycle of fetching m_pc
  bit          m_tgt_v = 0;
  logic [31:0] m_tgt = 32'h0;
  int          idle = 0;
  int          max_idle = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit legal(input logic [31:0] pc);
    longint p;
    p = longint'({32'h0, pc});
    return (pc[1:0] == 2'b00) && (p >= longint'(RESET_PC)) &&
           (p < longint'(RESET_PC) + longint'(IMEM_BYTES));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit ok;
    ok = legal(m_pc);
    chk("valid_f", {31'h0, valid_f}, {31'h0, m_ready});
    chk("pc_f", pc_f, m_pc);
    chk("instr_f", instr_f, (m_ready && ok) ? mem_word(m_pc) : 32'h0);
    chk("exc_f", {31'h0, exc_f}, {31'h0, m_ready && !ok});
    chk("imem_req", {31'h0, imem_req}, {31'h0, !m_ready && m_fresh && ok});
    if (imem_req === 1'b1) chk("imem_addr", imem_addr, m_pc);
  endtask

  // Advance the reference model across the coming edge using current inputs.
  task automatic model_edge();
    if (reset) begin
      m_pc = RESET_PC; m_ready = 0; m_fresh = 1; m_tgt_v = 0;
      model_on = 1; idle = 0;
    end else if (m_ready && !stall) begin
      if (redirect_en)  m_pc = redirect_pc;
      else if (m_tgt_v) m_pc = m_tgt;
      else              m_pc = m_pc + 32'd4;
      m_tgt_v = 0; m_ready = 0; m_fresh = 1; idle = 0;
    end else begin
      if (!stall && redirect_en) begin m_tgt = redirect_pc; m_tgt_v = 1; end
      if (!m_ready) begin
        if (!legal(m_pc))                 m_ready = 1;
        else if (!m_fresh && imem_rvalid) m_ready = 1;
        m_fresh = 0;
      end
      idle++;
      if (idle > max_idle) max_idle = idle;
    end
  endtask

  task automatic tick();
    logic        req_now;
    logic [31:0] addr_now;
    bit          rst_now;
    if (model_on) check_model();
    req_now  = imem_req;
    addr_now = imem_addr;
    rst_now  = reset;
    model_edge();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (rst_now) pend = 0;
    else if (req_now === 1'b1) begin pend = 1; cnt = lat; pend_addr = addr_now; end
    if (pend) begin
      if (cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend = 0;
      end else cnt--;
    end else if (spurious_en && $urandom_range(0, 9) == 0) begin
      imem_rvalid = 1'b1;
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60 && valid_f !== 1'b1; i++) tick();
    chk("wait_valid", {31'h0, valid_f}, 32'h1);
  endtask

  task automatic consume();
    wait_valid();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state, then back-to-back fetches at latency 1.
    lat = 1;
    do_reset();
    chk("rst_req", {31'h0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_pc_f", pc_f, 32'h3000);
    chk("rst_valid", {31'h0, valid_f}, 32'h0);
    chk("rst_instr", instr_f, 32'h0);
    chk("rst_exc", {31'h0, exc_f}, 32'h0);
    for (int i = 0; i < 9; i++) begin
      chk("run_valid", {31'h0, valid_f}, (i % 3 == 2) ? 32'h1 : 32'h0);
      if (i % 3 == 0) chk("run_addr", imem_addr, 32'h3000 + 32'(4 * (i / 3)));
      if (i % 3 == 2) chk("run_pc_f", pc_f, 32'h3000 + 32'(4 * (i / 3)));
      tick();
    end

    // Latency 4, stall held for five cycles on the 0x3008 slot.
    lat = 4;
    do_reset();
    consume();
    consume();
    wait_valid();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_pc_f", pc_f, 32'h3008);
      chk("stall_instr", instr_f, mem_word(32'h3008));
      chk("stall_req", {31'h0, imem_req}, 32'h0);
      tick();
    end
    stall = 1'b0;
    tick();
    chk("post_stall_req", {31'h0, imem_req}, 32'h1);
    chk("post_stall_addr", imem_addr, 32'h300C);

    // Redirect captured while 0x3014 is in flight.
    consume();          // 0x300C
    consume();          // 0x3010
    tick();             // 0x3014 issued, now waiting
    redirect_en = 1'b1; redirect_pc = 32'h3100;
    tick();
    redirect_en = 1'b0;
    wait_valid();
    chk("dslot_pc_f", pc_f, 32'h3014);
    chk("dslot_instr", instr_f, mem_word(32'h3014));
    tick();
    chk("redir_req", {31'h0, imem_req}, 32'h1);
    chk("redir_addr", imem_addr, 32'h3100);

    // Redirect on the same edge the 0x3014 slot is consumed.
    lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) consume();
    wait_valid();
    chk("same_edge_pc_f", pc_f, 32'h3014);
    redirect_en = 1'b1; redirect_pc = 32'h3100;
    tick();
    redirect_en = 1'b0;
    chk("same_edge_addr", imem_addr, 32'h3100);
    consume();
    chk("no_stale_tgt_req", {31'h0, imem_req}, 32'h1);
    chk("no_stale_tgt_addr", imem_addr, 32'h3104);

    // Misaligned and out-of-range targets become fault slots.
    wait_valid();
    redirect_en = 1'b1; redirect_pc = 32'h3002;
    tick();
    redirect_en = 1'b0;
    chk("misal_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("misal_valid", {31'h0, valid_f}, 32'h1);
    chk("misal_exc", {31'h0, exc_f}, 32'h1);
    chk("misal_instr", instr_f, 32'h0);
    chk("misal_pc_f", pc_f, 32'h3002);
    redirect_en = 1'b1; redirect_pc = 32'h7000;
    tick();
    redirect_en = 1'b0;
    chk("oor_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("oor_valid", {31'h0, valid_f}, 32'h1);
    chk("oor_exc", {31'h0, exc_f}, 32'h1);
    chk("oor_instr", instr_f, 32'h0);
    chk("oor_pc_f", pc_f, 32'h7000);
    redirect_en = 1'b1; redirect_pc = 32'h3200;
    tick();
    redirect_en = 1'b0;
    chk("recover_addr", imem_addr, 32'h3200);

    // Reset while waiting with a captured target pending.
    lat = 4;
    consume();          // 0x3200
    tick();             // 0x3204 issued
    redirect_en = 1'b1; redirect_pc = 32'h3300;
    tick();
    redirect_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_pc_f", pc_f, 32'h3000);
    chk("midrst_valid", {31'h0, valid_f}, 32'h0);
    chk("midrst_req", {31'h0, imem_req}, 32'h1);
    chk("midrst_addr", imem_addr, 32'h3000);
    consume();
    chk("midrst_tgt_lost", imem_addr, 32'h3004);

    // Randomized traffic against the reference model.
    spurious_en = 1;
    max_idle = 0;
    for (int i = 0; i < 1500; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect_en = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 9))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = RESET_PC + 32'($urandom_range(0, 32'h0FFF) * 4) + 32'd2;
        2:       redirect_pc = RESET_PC + IMEM_BYTES - 32'd4;
        default: redirect_pc = RESET_PC + 32'($urandom_range(0, 32'h0FFF) * 4);
      endcase
      reset = ($urandom_range(0, 299) == 0);
      lat   = $urandom_range(1, 5);
      tick();
    end
    stall = 1'b0; redirect_en = 1'b0; reset = 1'b0;
    chk("progress", {31'h0, max_idle < 64}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
